// File: rtl/branch_target_buffer_pkg.sv
// Shared RV32I fetch-prediction types: BTB geometry, prediction/entry structs,
// PC increment helper and the 2-bit saturating direction counter.
package branch_target_buffer_pkg;

  localparam int XLEN            = 32;
  localparam int BTB_SIZE        = 64;
  localparam int BTB_INDEX_WIDTH = $clog2(BTB_SIZE);
  localparam int BTB_TAG_WIDTH   = XLEN - BTB_INDEX_WIDTH - 2;

  typedef enum logic [1:0] {
    PRED_STRONG_NOT_TAKEN = 2'b00,
    PRED_WEAK_NOT_TAKEN   = 2'b01,
    PRED_WEAK_TAKEN       = 2'b10,
    PRED_STRONG_TAKEN     = 2'b11
  } branch_pred_state_e;

  typedef struct packed {
    logic               valid;
    logic               taken;
    logic [XLEN-1:0]    target;
    branch_pred_state_e state;
  } branch_pred_t;

  typedef struct packed {
    logic                     valid;
    logic [BTB_TAG_WIDTH-1:0] tag;
    logic [XLEN-1:0]          target;
    logic                     is_jump;
    branch_pred_state_e       state;
  } btb_entry_t;

  function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
    return pc + XLEN'(4);
  endfunction

  function automatic branch_pred_state_e pred_next_state(input branch_pred_state_e s,
                                                         input logic taken);
    branch_pred_state_e n;
    case (s)
      PRED_STRONG_NOT_TAKEN: n = taken ? PRED_WEAK_NOT_TAKEN : PRED_STRONG_NOT_TAKEN;
      PRED_WEAK_NOT_TAKEN:   n = taken ? PRED_WEAK_TAKEN     : PRED_STRONG_NOT_TAKEN;
      PRED_WEAK_TAKEN:       n = taken ? PRED_STRONG_TAKEN   : PRED_WEAK_NOT_TAKEN;
      PRED_STRONG_TAKEN:     n = taken ? PRED_STRONG_TAKEN   : PRED_WEAK_TAKEN;
      default:               n = PRED_WEAK_NOT_TAKEN;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/branch_target_buffer_if.sv
// Lookup (IF side) and training (EX side) signals of the branch target buffer.
// master = pipeline that drives PCs/outcomes, slave = the BTB itself.
interface branch_target_buffer_if;
  import branch_target_buffer_pkg::*;

  logic [XLEN-1:0] lookup_pc;
  branch_pred_t    pred;
  logic            upd_valid;
  logic [XLEN-1:0] upd_pc;
  logic            upd_is_jump;
  logic            upd_taken;
  logic [XLEN-1:0] upd_target;

  modport master (
    output lookup_pc, upd_valid, upd_pc, upd_is_jump, upd_taken, upd_target,
    input  pred
  );

  modport slave (
    input  lookup_pc, upd_valid, upd_pc, upd_is_jump, upd_taken, upd_target,
    output pred
  );
endinterface

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB with 2-bit counters: combinational lookup, one-edge training.
// Define BTB_BYPASS_EN to forward a same-cycle, same-index update to the lookup.
module branch_target_buffer #(
  parameter int BTB_SIZE = branch_target_buffer_pkg::BTB_SIZE,
  parameter int XLEN     = branch_target_buffer_pkg::XLEN
) (
  input  logic                 clk,
  input  logic                 rst,
  branch_target_buffer_if.slave bus
);
  import branch_target_buffer_pkg::*;

  localparam int IDX_W = $clog2(BTB_SIZE);
  localparam int TAG_W = XLEN - IDX_W - 2;

  logic [BTB_SIZE-1:0] valid_q;
  logic [BTB_SIZE-1:0] jump_q;
  logic [TAG_W-1:0]    tag_q    [BTB_SIZE];
  logic [XLEN-1:0]     target_q [BTB_SIZE];
  branch_pred_state_e  state_q  [BTB_SIZE];

  logic [IDX_W-1:0] lk_idx, upd_idx;
  logic [TAG_W-1:0] lk_tag, upd_tag;
  logic             unused_pc_lsbs;

  assign lk_idx  = bus.lookup_pc[IDX_W+1:2];
  assign lk_tag  = bus.lookup_pc[XLEN-1:IDX_W+2];
  assign upd_idx = bus.upd_pc[IDX_W+1:2];
  assign upd_tag = bus.upd_pc[XLEN-1:IDX_W+2];
  assign unused_pc_lsbs = ^{bus.lookup_pc[1:0], bus.upd_pc[1:0]};

  // Training: an entry whose kind (jump/branch) disagrees counts as a miss
  logic               upd_hit;
  logic               wr_en;
  logic [XLEN-1:0]    wr_target;
  branch_pred_state_e wr_state;

  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag) &&
                   (jump_q[upd_idx] == bus.upd_is_jump);

  always_comb begin
    wr_en     = 1'b0;
    wr_target = target_q[upd_idx];
    wr_state  = state_q[upd_idx];
    if (bus.upd_valid && !rst) begin
      if (upd_hit) begin
        wr_en = 1'b1;
        if (bus.upd_is_jump) begin
          wr_state  = PRED_STRONG_TAKEN;
          wr_target = bus.upd_target;
        end else begin
          wr_state = pred_next_state(state_q[upd_idx], bus.upd_taken);
          if (bus.upd_taken) wr_target = bus.upd_target;
        end
      end else if (bus.upd_taken) begin
        wr_en     = 1'b1;
        wr_target = bus.upd_target;
        wr_state  = bus.upd_is_jump ? PRED_STRONG_TAKEN : PRED_WEAK_TAKEN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[upd_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      jump_q[upd_idx]   <= bus.upd_is_jump;
      tag_q[upd_idx]    <= upd_tag;
      target_q[upd_idx] <= wr_target;
      state_q[upd_idx]  <= wr_state;
    end
  end

  // Lookup: read the indexed entry, optionally overridden by this cycle's write
  logic               rd_valid;
  logic               rd_jump;
  logic [TAG_W-1:0]   rd_tag;
  logic [XLEN-1:0]    rd_target;
  branch_pred_state_e rd_state;
  logic               hit;
  branch_pred_t       pred_c;

  always_comb begin
    rd_valid  = valid_q[lk_idx];
    rd_jump   = jump_q[lk_idx];
    rd_tag    = tag_q[lk_idx];
    rd_target = target_q[lk_idx];
    rd_state  = state_q[lk_idx];
`ifdef BTB_BYPASS_EN
    if (wr_en && (lk_idx == upd_idx)) begin
      rd_valid  = 1'b1;
      rd_jump   = bus.upd_is_jump;
      rd_tag    = upd_tag;
      rd_target = wr_target;
      rd_state  = wr_state;
    end
`endif
    hit = rd_valid && (rd_tag == lk_tag);
    if (hit) begin
      pred_c.valid  = 1'b1;
      pred_c.taken  = rd_jump | rd_state[1];
      pred_c.target = rd_target;
      pred_c.state  = rd_state;
    end else begin
      pred_c.valid  = 1'b0;
      pred_c.taken  = 1'b0;
      pred_c.target = pc_plus4(bus.lookup_pc);
      pred_c.state  = PRED_WEAK_NOT_TAKEN;
    end
  end

  assign bus.pred = pred_c;

endmodule
